// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter: FSM state encoding
// and default data/timeout widths.
package uart_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 1024;

    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_START_ENC     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY_ENC = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_START     = ST_START_ENC,
        ST_WAIT_BUSY = ST_WAIT_BUSY_ENC,
        ST_WAIT_DONE = ST_WAIT_DONE_ENC
    } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority pick: first set req bit searching upward from
// last_grant+1, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last_grant,
    output logic             grant_valid,
    output logic [2:0]       grant_idx
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] idx;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = IW'((int'(last_grant) + off) % N_REQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte requesters.
// Define UART_ARB_TIMEOUT_EN to enable the tx_busy rise timeout and err_timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                    MAX10_CLK1_50,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic [2:0]              owner,
    output logic                    arb_busy,
    output logic                    err_timeout
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_tx_arbiter: illegal N_REQ or TIMEOUT_CYC");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        last_grant_q, last_grant_d;
    logic [N_REQ-1:0]  req_ack_q, req_ack_d;
    logic              grant_valid;
    logic [2:0]        grant_idx;
    logic              timeout_hit;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             in_wait_busy;

    assign in_wait_busy = (state_q == ST_WAIT_BUSY) && !tx_busy;
    assign timeout_hit  = (cnt_q == CNT_LAST);

    // Counter restarts from zero on every entry into WAIT_BUSY.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (in_wait_busy) begin
            if (timeout_hit) err_d = 1'b1;
            else             cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        req_ack_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_busy && grant_valid) begin
                    tx_data_d = req_data[int'(grant_idx)*DATA_W +: DATA_W];
                    owner_d   = grant_idx;
                    req_ack_d = N_REQ'(1) << grant_idx;
                    state_d   = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= '0;
            owner_q      <= '0;
            last_grant_q <= 3'(N_REQ - 1);
            req_ack_q    <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            req_ack_q    <= req_ack_d;
        end
    end

    assign req_ack  = req_ack_q;
    assign tx_data  = tx_data_q;
    assign owner    = owner_q;
    assign tx_start = (state_q == ST_START);
    assign arb_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected grants,
// UART busy model, directed scenarios for arbitration, reset and timeout.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N_REQ       = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;

    typedef struct packed {
        logic [2:0]        idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                    MAX10_CLK1_50 = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_start;
    logic                    tx_busy;
    logic [2:0]              owner;
    logic                    arb_busy;
    logic                    err_timeout;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_start = 0;
    int   n_ack   = 0;
    int   rep_left [N_REQ];
    logic model_busy = 1'b0;
    logic ext_busy   = 1'b0;
    logic busy_stuck = 1'b0;
    int   busy_dly   = 0;
    int   busy_hold  = 0;

    assign tx_busy = model_busy | ext_busy;

    always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    uart_tx_arbiter #(
        .N_REQ       (N_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .MAX10_CLK1_50 (MAX10_CLK1_50),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .req_ack       (req_ack),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .owner         (owner),
        .arb_busy      (arb_busy),
        .err_timeout   (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int idx, input logic [DATA_W-1:0] d);
        exp_t e;
        e.idx  = 3'(idx);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock cycle: sample at the falling edge, score, then update models.
    task automatic step();
        exp_t e;
        @(negedge MAX10_CLK1_50);
        chk("ack_popcount_le1", 32'($countones(req_ack) <= 1), 32'd1);
        chk("no_start_while_busy", 32'(tx_start & tx_busy), 32'd0);
        if (tx_start) n_start++;
        if (req_ack != '0) begin
            n_ack++;
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(req_ack), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_vec", 32'(req_ack), 32'd1 << e.idx);
                chk("owner", 32'(owner), 32'(e.idx));
                chk("tx_data", 32'(tx_data), 32'(e.data));
                chk("tx_start_with_ack", 32'(tx_start), 32'd1);
                chk("arb_busy_with_ack", 32'(arb_busy), 32'd1);
            end
        end
        if (busy_hold > 0) begin
            busy_hold--;
            if (busy_hold == 0) model_busy = 1'b0;
        end else if (busy_dly > 0) begin
            busy_dly--;
            if (busy_dly == 0) begin
                model_busy = 1'b1;
                busy_hold  = 10;
            end
        end
        if (tx_start && !busy_stuck) busy_dly = 2;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ack[i]) begin
                if (rep_left[i] > 0) rep_left[i]--;
                else                 req[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || req != '0 || arb_busy || tx_busy) && cyc < 500) begin
            step();
            cyc++;
        end
        chk({tag, "_drained"}, 32'(cyc < 500), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge MAX10_CLK1_50);
        reset      = 1'b0;
        req        = '0;
        model_busy = 1'b0;
        ext_busy   = 1'b0;
        busy_dly   = 0;
        busy_hold  = 0;
        exp_q.delete();
        repeat (2) @(negedge MAX10_CLK1_50);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        for (int i = 0; i < N_REQ; i++) rep_left[i] = 0;

        // Reset values
        repeat (2) @(negedge MAX10_CLK1_50);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_req_ack", 32'(req_ack), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        reset = 1'b1;

        // Single request from requester 2
        n_start = 0; n_ack = 0;
        req_data[2*DATA_W +: DATA_W] = 8'h5A;
        req = 4'b0100;
        push_exp(2, 8'h5A);
        drain("single");
        chk("single_starts", 32'(n_start), 32'd1);
        chk("single_acks", 32'(n_ack), 32'd1);
        chk("single_tx_data_hold", 32'(tx_data), 32'h5A);

        // All four requesters held: served 0,1,2,3 after reset
        do_reset();
        n_start = 0; n_ack = 0;
        for (int i = 0; i < N_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = 8'(8'h10 + i);
            push_exp(i, 8'(8'h10 + i));
        end
        req = 4'b1111;
        drain("all4");
        chk("all4_starts", 32'(n_start), 32'd4);
        chk("all4_acks", 32'(n_ack), 32'd4);

        // Fairness: req0 re-asserted after each ack, req3 held
        do_reset();
        n_ack = 0;
        req_data[0*DATA_W +: DATA_W] = 8'hA0;
        req_data[3*DATA_W +: DATA_W] = 8'hA3;
        rep_left[0] = 1;
        rep_left[3] = 1;
        push_exp(0, 8'hA0);
        push_exp(3, 8'hA3);
        push_exp(0, 8'hA0);
        push_exp(3, 8'hA3);
        req = 4'b1001;
        drain("fair");
        chk("fair_acks", 32'(n_ack), 32'd4);

        // Reset pulsed during WAIT_DONE
        do_reset();
        req_data[1*DATA_W +: DATA_W] = 8'h77;
        push_exp(1, 8'h77);
        req = 4'b0010;
        cyc = 0;
        while (!tx_busy && cyc < 50) begin
            step();
            cyc++;
        end
        chk("abort_busy_seen", 32'(tx_busy), 32'd1);
        step();
        chk("abort_in_wait_done", 32'(arb_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_tx_start", 32'(tx_start), 32'd0);
        chk("abort_req_ack", 32'(req_ack), 32'd0);
        chk("abort_tx_data", 32'(tx_data), 32'd0);
        chk("abort_owner", 32'(owner), 32'd0);
        chk("abort_arb_busy", 32'(arb_busy), 32'd0);
        chk("abort_err", 32'(err_timeout), 32'd0);
        step();
        step();
        reset   = 1'b1;
        n_start = 0; n_ack = 0;
        repeat (5) step();
        chk("abort_quiet_starts", 32'(n_start), 32'd0);
        chk("abort_quiet_acks", 32'(n_ack), 32'd0);
        req_data[3*DATA_W +: DATA_W] = 8'hC3;
        push_exp(3, 8'hC3);
        req = 4'b1000;
        drain("abort_after");
        chk("abort_after_acks", 32'(n_ack), 32'd1);

        // External tx_busy blocks grant in IDLE
        n_ack = 0;
        ext_busy = 1'b1;
        req_data[0*DATA_W +: DATA_W] = 8'h3C;
        push_exp(0, 8'h3C);
        req = 4'b0001;
        repeat (5) step();
        chk("extbusy_no_grant", 32'(arb_busy), 32'd0);
        chk("extbusy_no_ack", 32'(n_ack), 32'd0);
        ext_busy = 1'b0;
        step();
        chk("extbusy_ack_next_edge", 32'(req_ack), 32'b0001);
        drain("extbusy");

`ifdef UART_ARB_TIMEOUT_EN
        // tx_busy never rises: timeout after 16 WAIT_BUSY cycles
        busy_stuck = 1'b1;
        req_data[1*DATA_W +: DATA_W] = 8'h21;
        push_exp(1, 8'h21);
        req = 4'b0010;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("to_granted", 32'(exp_q.size()), 32'd0);
        repeat (16) step();
        chk("to_still_waiting", 32'(arb_busy), 32'd1);
        chk("to_err_not_yet", 32'(err_timeout), 32'd0);
        step();
        chk("to_back_idle", 32'(arb_busy), 32'd0);
        chk("to_err_set", 32'(err_timeout), 32'd1);
        busy_stuck = 1'b0;
        req_data[2*DATA_W +: DATA_W] = 8'h42;
        push_exp(2, 8'h42);
        req = 4'b0100;
        drain("to_next");
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
`else
        chk("no_timeout_err_tied", 32'(err_timeout), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
